// File: rtl/palette_pkg.sv
// Shared widths, color type and chroma-key default for the palette lookup path.
package palette_pkg;

    localparam int unsigned PAL_IDX_W = 4;
    localparam int unsigned RGB_W     = 12;
    localparam int unsigned ID_W      = 3;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    localparam logic [RGB_W-1:0] KEY_RGB_DEFAULT = 12'hF0D;

    // A pixel is drawn unless its looked-up color is the chroma key.
    function automatic logic is_opaque(input rgb_t color, input rgb_t key);
        return color != key;
    endfunction

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Requester, palette and response signals shared between the sprite readers and the arbiter.
interface palette_lookup_arbiter_if #(
    parameter int unsigned N_REQ = 5
);
    import palette_pkg::*;

    logic [N_REQ-1:0]           req;
    logic [PAL_IDX_W*N_REQ-1:0] req_idx;
    logic [N_REQ-1:0]           gnt;
    logic [PAL_IDX_W-1:0]       pal_index;
    rgb_t                       pal_rgb;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    rgb_t                       rsp_rgb;
    logic                       rsp_opaque;
    logic                       rsp_ready;

    modport master (
        output req, req_idx, pal_rgb, rsp_ready,
        input  gnt, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_opaque
    );

    modport slave (
        input  req, req_idx, pal_rgb, rsp_ready,
        output gnt, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_opaque
    );

endinterface

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt
);

    localparam int unsigned PTR_W = $clog2(N);

    logic             found;
    logic [PTR_W-1:0] pos;

    // ptr is always below N, so one conditional subtract is enough to wrap.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return PTR_W'(sum);
    endfunction

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = wrap_add(ptr, k);
            if (en && !found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Round-robin share of the single palette lookup among sprite requesters, two-stage
// pipeline (index, then color) returning RGB, requester ID and a transparency flag.
module palette_lookup_arbiter
    import palette_pkg::*;
#(
    parameter int unsigned      N_REQ   = 5,
    parameter logic [RGB_W-1:0] KEY_RGB = KEY_RGB_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    palette_lookup_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]     ptr,         ptr_nxt;
    logic                 s1_valid,    s1_valid_nxt;
    logic [ID_W-1:0]      s1_id,       s1_id_nxt;
    logic [PAL_IDX_W-1:0] pal_index_q, pal_index_nxt;
    logic                 rsp_valid_q, rsp_valid_nxt;
    logic [ID_W-1:0]      rsp_id_q,    rsp_id_nxt;
    rgb_t                 rsp_rgb_q,   rsp_rgb_nxt;
    logic                 rsp_opaque_q, rsp_opaque_nxt;

    logic                 stall;
    logic                 arb_en;
    logic [N_REQ-1:0]     gnt;
    logic                 gnt_any;
    logic [ID_W-1:0]      gnt_id;
    logic [PAL_IDX_W-1:0] gnt_idx;

    // A held response freezes the whole pipe, and no new grant may enter it.
    assign stall  = rsp_valid_q & ~bus.rsp_ready;
    assign arb_en = ~stall & ~reset;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr_arbiter (
        .req(bus.req),
        .ptr(ptr),
        .en (arb_en),
        .gnt(gnt)
    );

    assign gnt_any = |gnt;

    // Encode the one-hot grant and pick the winner's palette index.
    always_comb begin
        gnt_id  = '0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id  = ID_W'(i);
                gnt_idx = bus.req_idx[i*PAL_IDX_W +: PAL_IDX_W];
            end
        end
    end

    // Next-state: S1 and S2 advance together whenever the response is free or taken.
    always_comb begin
        ptr_nxt        = ptr;
        s1_valid_nxt   = s1_valid;
        s1_id_nxt      = s1_id;
        pal_index_nxt  = pal_index_q;
        rsp_valid_nxt  = rsp_valid_q;
        rsp_id_nxt     = rsp_id_q;
        rsp_rgb_nxt    = rsp_rgb_q;
        rsp_opaque_nxt = rsp_opaque_q;

        if (!stall) begin
            s1_valid_nxt   = gnt_any;
            rsp_valid_nxt  = s1_valid;
            rsp_id_nxt     = s1_id;
            rsp_rgb_nxt    = bus.pal_rgb;
            rsp_opaque_nxt = is_opaque(bus.pal_rgb, rgb_t'(KEY_RGB));
            if (gnt_any) begin
                s1_id_nxt     = gnt_id;
                pal_index_nxt = gnt_idx;
                ptr_nxt       = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : PTR_W'(gnt_id + ID_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            s1_valid     <= 1'b0;
            s1_id        <= '0;
            pal_index_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_rgb_q    <= '0;
            rsp_opaque_q <= 1'b0;
        end else begin
            ptr          <= ptr_nxt;
            s1_valid     <= s1_valid_nxt;
            s1_id        <= s1_id_nxt;
            pal_index_q  <= pal_index_nxt;
            rsp_valid_q  <= rsp_valid_nxt;
            rsp_id_q     <= rsp_id_nxt;
            rsp_rgb_q    <= rsp_rgb_nxt;
            rsp_opaque_q <= rsp_opaque_nxt;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.pal_index  = pal_index_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_rgb    = rsp_rgb_q;
    assign bus.rsp_opaque = rsp_opaque_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: latency, transparency, fairness,
// backpressure, mid-stream reset and pointer wrap.
module tb_palette_lookup_arbiter;
    import palette_pkg::*;

    localparam int unsigned N = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cnt [N];

    always #5 clk = ~clk;

    palette_lookup_arbiter_if #(.N_REQ(N)) bus ();

    palette_lookup_arbiter #(
        .N_REQ  (N),
        .KEY_RGB(12'hF0D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Palette contents seen by the DUT: 0 is white, 5 is the chroma key.
    function automatic logic [11:0] pal_of(input logic [3:0] i);
        case (i)
            4'h0:    return 12'hFFF;
            4'h5:    return 12'hF0D;
            default: return {i, ~i, 4'h8};
        endcase
    endfunction

    assign bus.pal_rgb = pal_of(bus.pal_index);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = '1;
        bus.req_idx   = '0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("gnt_during_reset", 32'(bus.gnt), 32'h0);
        step();
        step();
        chk("rst_gnt",        32'(bus.gnt), 32'h0);
        chk("rst_pal_index",  32'(bus.pal_index), 32'h0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_id",     32'(bus.rsp_id), 32'h0);
        chk("rst_rsp_rgb",    32'(bus.rsp_rgb), 32'h0);
        chk("rst_rsp_opaque", 32'(bus.rsp_opaque), 32'h0);
        chk("rst_ptr",        32'(dut.ptr), 32'h0);
        reset   = 1'b0;
        bus.req = '0;

        // Single request from requester 2, index 0.
        bus.req = 5'b00100;
        #1;
        chk("single_gnt", 32'(bus.gnt), 32'h04);
        step();
        bus.req = '0;
        chk("single_pal_index", 32'(bus.pal_index), 32'h0);
        chk("single_t1_valid",  32'(bus.rsp_valid), 32'h0);
        step();
        chk("single_valid",  32'(bus.rsp_valid), 32'h1);
        chk("single_id",     32'(bus.rsp_id), 32'h2);
        chk("single_rgb",    32'(bus.rsp_rgb), 32'hFFF);
        chk("single_opaque", 32'(bus.rsp_opaque), 32'h1);
        chk("single_ptr",    32'(dut.ptr), 32'h3);
        step();
        chk("single_done", 32'(bus.rsp_valid), 32'h0);

        // Transparency: requester 0 with index 5 (ptr 3 wraps to 0).
        bus.req_idx[3:0] = 4'h5;
        bus.req          = 5'b00001;
        #1;
        chk("key_gnt", 32'(bus.gnt), 32'h01);
        step();
        bus.req = '0;
        chk("key_pal_index", 32'(bus.pal_index), 32'h5);
        step();
        chk("key_valid",  32'(bus.rsp_valid), 32'h1);
        chk("key_id",     32'(bus.rsp_id), 32'h0);
        chk("key_rgb",    32'(bus.rsp_rgb), 32'hF0D);
        chk("key_opaque", 32'(bus.rsp_opaque), 32'h0);
        chk("key_ptr",    32'(dut.ptr), 32'h1);
        step();

        // Fairness: all requesters held for 10 cycles; requester r uses index r+1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("fair_ptr0", 32'(dut.ptr), 32'h0);
        for (int i = 0; i < int'(N); i++) begin
            bus.req_idx[i*4 +: 4] = 4'(i + 1);
            cnt[i] = 0;
        end
        bus.req = '1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("fair_gnt", 32'(bus.gnt), 32'(1 << (k % 5)));
            for (int i = 0; i < int'(N); i++) begin
                if (bus.gnt[i]) cnt[i]++;
            end
            if (k >= 2) begin
                chk("fair_rsp_valid", 32'(bus.rsp_valid), 32'h1);
                chk("fair_rsp_id",    32'(bus.rsp_id), 32'((k - 2) % 5));
                chk("fair_rsp_rgb",   32'(bus.rsp_rgb), 32'(pal_of(4'(((k - 2) % 5) + 1))));
            end
            step();
        end
        bus.req = '0;
        for (int i = 0; i < int'(N); i++) begin
            chk("fair_count", 32'(cnt[i]), 32'h2);
        end
        step();
        step();
        step();

        // Backpressure: two grants, then three stalled cycles, then resume.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = '1;
        #1;
        chk("bp_gnt_c0", 32'(bus.gnt), 32'h01);
        step();
        #1;
        chk("bp_gnt_c1", 32'(bus.gnt), 32'h02);
        step();
        for (int s = 0; s < 3; s++) begin
            bus.rsp_ready = 1'b0;
            #1;
            chk("bp_stall_gnt",   32'(bus.gnt), 32'h0);
            chk("bp_stall_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_stall_id",    32'(bus.rsp_id), 32'h0);
            chk("bp_stall_rgb",   32'(bus.rsp_rgb), 32'(pal_of(4'h1)));
            chk("bp_stall_ptr",   32'(dut.ptr), 32'h2);
            chk("bp_stall_index", 32'(bus.pal_index), 32'h2);
            step();
        end
        for (int j = 0; j < 7; j++) begin
            bus.rsp_ready = 1'b1;
            #1;
            chk("bp_resume_gnt",   32'(bus.gnt), 32'(1 << ((2 + j) % 5)));
            chk("bp_resume_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_resume_id",    32'(bus.rsp_id), 32'(j % 5));
            step();
        end

        // Reset with both stages full: nothing in flight survives.
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        step();
        reset   = 1'b0;
        bus.req = '0;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_index", 32'(bus.pal_index), 32'h0);
        chk("mid_rst_ptr",   32'(dut.ptr), 32'h0);
        step();
        chk("mid_rst_no_stale", 32'(bus.rsp_valid), 32'h0);

        // Wrap and skip: move ptr to 3, then only requesters 1 and 3 compete.
        bus.req = 5'b00100;
        #1;
        chk("wrap_setup_gnt", 32'(bus.gnt), 32'h04);
        step();
        bus.req = 5'b01010;
        chk("wrap_ptr3", 32'(dut.ptr), 32'h3);
        #1;
        chk("wrap_gnt_a", 32'(bus.gnt), 32'h08);
        step();
        #1;
        chk("wrap_ptr4",  32'(dut.ptr), 32'h4);
        chk("wrap_gnt_b", 32'(bus.gnt), 32'h02);
        step();
        #1;
        chk("wrap_ptr2",  32'(dut.ptr), 32'h2);
        chk("wrap_gnt_c", 32'(bus.gnt), 32'h08);
        step();
        chk("wrap_ptr4b", 32'(dut.ptr), 32'h4);
        bus.req = 5'b10000;
        #1;
        chk("wrap_gnt_last", 32'(bus.gnt), 32'h10);
        step();
        bus.req = '0;
        chk("wrap_ptr_zero", 32'(dut.ptr), 32'h0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
